// File: rtl/timx_pwmin_pkg.sv
// Shared types and defaults for the multi-channel PWM-input capture unit.
package timx_pwmin_pkg;

  localparam int unsigned DEF_CH_NUM     = 4;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_FLT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_e;

  // Pointer width for a power-of-two FIFO; never below one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/timx_pwmin_chan.sv
// One PWM-input channel: synchroniser, optional filter, edge detect,
// measurement FSM/counter and show-ahead capture FIFO.
// Filter present only when TIMX_PWMIN_FILTER_EN is defined.
module timx_pwmin_chan
  import timx_pwmin_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned FLT_W      = DEF_FLT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             en,
  input  logic             pol,
  input  logic [FLT_W-1:0] flt_len,
  input  logic             raw,
  input  logic             pop,
  input  logic             ovf_clr,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] width,
  output logic             ovf,
  output logic             sat
);

  localparam int unsigned    PW      = ptr_w(FIFO_DEPTH);
  localparam logic [PW:0]    DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic s1, s2, filt, filt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (!en) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

`ifdef TIMX_PWMIN_FILTER_EN
  logic [FLT_W-1:0] run;

  // Level follows s2 once it has disagreed for flt_len samples; a match restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b0;
      run  <= '0;
    end else if (!en) begin
      filt <= 1'b0;
      run  <= '0;
    end else if (s2 == filt) begin
      run <= '0;
    end else if (run >= flt_len) begin
      filt <= s2;
      run  <= '0;
    end else begin
      run <= run + 1'b1;
    end
  end
`else
  logic unused_flt;
  assign unused_flt = ^flt_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) filt <= 1'b0;
    else        filt <= en ? s2 : 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) filt_d <= 1'b0;
    else        filt_d <= en ? filt : 1'b0;
  end

  // Polarity applied to both samples so a pol=1 channel sees no edge out of reset.
  logic lvl, lvl_d, act, inact;
  assign lvl   = filt ^ pol;
  assign lvl_d = filt_d ^ pol;
  assign act   = en & lvl & ~lvl_d;
  assign inact = en & ~lvl & lvl_d;

  pwm_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, wid, wid_n, restart, push_w;
  logic             push, sat_n;

  assign restart = CNT_W'(tick);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      wid   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      wid   <= wid_n;
      sat   <= sat_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wid_n   = wid;
    push    = 1'b0;
    push_w  = wid;
    sat_n   = 1'b0;
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      if (tick && cnt != CNT_MAX) cnt_n = cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (act) begin
            state_n = HIGH;
            cnt_n   = restart;
          end
        end
        HIGH: begin
          if (act) begin
            push   = 1'b1;
            push_w = cnt;
            wid_n  = cnt;
            cnt_n  = restart;
          end else if (inact) begin
            wid_n   = cnt;
            state_n = LOW;
          end else if (tick && cnt == CNT_MAX) begin
            sat_n   = 1'b1;
            state_n = IDLE;
          end
        end
        LOW: begin
          if (act) begin
            push    = 1'b1;
            state_n = HIGH;
            cnt_n   = restart;
          end else if (tick && cnt == CNT_MAX) begin
            sat_n   = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  logic [2*CNT_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW:0]        count;
  logic               full, empty, pop_ok, push_ok, drop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {cnt, push_w};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign valid           = ~empty;
  assign {period, width} = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/timx_pwmin_capture.sv
// Multi-channel PWM-input capture: CH_NUM copies of timx_pwmin_chan with packed buses.
// Digital filter enabled by defining TIMX_PWMIN_FILTER_EN.
module timx_pwmin_capture
  import timx_pwmin_pkg::*;
#(
  parameter int unsigned CH_NUM     = DEF_CH_NUM,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned FLT_W      = DEF_FLT_W
) (
  input  logic                    apb_clk,
  input  logic                    apb_rst_n,
  input  logic                    psc_tick,
  input  logic [CH_NUM-1:0]       ch_en,
  input  logic [CH_NUM-1:0]       ch_pol,
  input  logic [FLT_W-1:0]        flt_len,
  input  logic [CH_NUM-1:0]       ch_in,
  input  logic [CH_NUM-1:0]       cap_pop,
  input  logic [CH_NUM-1:0]       ovf_clr,
  output logic [CH_NUM-1:0]       cap_valid,
  output logic [CH_NUM*CNT_W-1:0] cap_period,
  output logic [CH_NUM*CNT_W-1:0] cap_width,
  output logic [CH_NUM-1:0]       cap_ovf,
  output logic [CH_NUM-1:0]       cnt_sat
);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    timx_pwmin_chan #(
      .CNT_W      (CNT_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .FLT_W      (FLT_W)
    ) u_chan (
      .clk     (apb_clk),
      .rst_n   (apb_rst_n),
      .tick    (psc_tick),
      .en      (ch_en[i]),
      .pol     (ch_pol[i]),
      .flt_len (flt_len),
      .raw     (ch_in[i]),
      .pop     (cap_pop[i]),
      .ovf_clr (ovf_clr[i]),
      .valid   (cap_valid[i]),
      .period  (cap_period[i*CNT_W +: CNT_W]),
      .width   (cap_width[i*CNT_W +: CNT_W]),
      .ovf     (cap_ovf[i]),
      .sat     (cnt_sat[i])
    );
  end

endmodule

// File: doc/timx_pwmin_capture.md
# timx_pwmin_capture

Multi-channel PWM-input measurement unit for the advanced timer family. It generalises the single-channel PWM-input mode (TI1 reset-mode slave, CC1 period / CC2 width) to CH_NUM independent channels with parametrised counter width. Each channel has an optional digital filter and a per-channel capture FIFO. It sits beside the timer core on the apb_clk domain: the prescaler supplies count ticks, and the register file pops results and reads the status flags.

## Interface
- CH_NUM, 4: number of independent input channels (1..8)
- CNT_W, 16: measurement counter and captured-value width (8..32)
- FIFO_DEPTH, 4: entries per channel FIFO, power of two (2..16)
- FLT_W, 4: width of filter-length field
- apb_clk  in  1  sole clock
- apb_rst_n  in  1  asynchronous, active-low reset
- psc_tick  in  1  one-cycle count strobe from prescaler; counters advance only on it
- ch_en  in  CH_NUM  per-channel enable
- ch_pol  in  CH_NUM  0: period starts on rising edge (width = high time); 1: falling edge (width = low time)
- flt_len  in  FLT_W  consecutive stable samples required before filtered level changes; 0 = bypass
- ch_in  in  CH_NUM  raw asynchronous inputs
- cap_pop  in  CH_NUM  pop head entry of channel FIFO
- ovf_clr  in  CH_NUM  clear sticky overflow flag
- cap_valid  out  CH_NUM  FIFO non-empty
- cap_period  out  CH_NUM*CNT_W  head entry period, channel i at [i*CNT_W +: CNT_W]
- cap_width  out  CH_NUM*CNT_W  head entry active width, same packing
- cap_ovf  out  CH_NUM  sticky: entry dropped because FIFO full
- cnt_sat  out  CH_NUM  one-cycle pulse: counter saturated, measurement abandoned

## Operation
- Per channel: 2-flop synchroniser -> filter -> polarity XOR -> edge detect (active edge = polarity-adjusted rising, inactive = falling).
- Filter: the filtered level takes the synced value only after it has differed from the current filtered level for flt_len consecutive cycles. Any glitch restarts the run count.
- Counter: on an active edge, counter <= psc_tick ? 1 : 0. Otherwise it increments on psc_tick and saturates at all-ones. The captured value is the counter value before update.
- FSM states:
  - IDLE: on active edge -> HIGH (counter restarted).
  - HIGH: on inactive edge, latch width -> LOW. On active edge (narrow pulse lost by filter), latch width = period, push -> HIGH.
  - LOW: on active edge, push {period = counter, width} and restart counter -> HIGH.
- Saturation in HIGH or LOW: pulse cnt_sat, go to IDLE, nothing is pushed. The next active edge starts fresh.
- ch_en low: FSM to IDLE, counter 0, filter and sync cleared, no pushes. FIFO contents and cap_ovf are retained. Pops remain legal.
- FIFO is show-ahead: cap_period and cap_width present the head while cap_valid = 1.
  - Pop on empty is ignored.
  - Push when full drops the new entry and sets cap_ovf.
  - Push and pop in the same cycle when full: both take effect, no overflow.
  - ovf_clr and a same-cycle overflow: set wins.
- Reset: all outputs 0, FSMs IDLE, FIFOs empty, counters 0, filtered levels 0.

## Timing
- ch_in transition sampled at clock edge E0 (bypass filter): edge recognised in the cycle after E2. Counter restart and FIFO write at E3. cap_valid high after E3.
- Filter adds flt_len cycles to that latency.
- Pop at edge Ep: next entry (or cap_valid = 0) visible after Ep.
- cnt_sat asserts for exactly one cycle, in the cycle after the counter reaches all-ones with a tick pending.
- Measurement is exact in ticks: with psc_tick tied high, period P cycles and high time H capture as P and H.

## Configuration
- TIMX_PWMIN_FILTER_EN defined: digital filter implemented as above.
- TIMX_PWMIN_FILTER_EN undefined: filtered level = synced level, flt_len is ignored (port retained), latency fixed at the bypass value.

## Structure
- Package timx_pwmin_pkg holds:
  - FSM state enum (IDLE/HIGH/LOW)
  - default parameter constants
  - localparam function for FIFO pointer width
- Sub-module timx_pwmin_chan holds one channel: sync, filter, FSM, counter and FIFO. The top generates it CH_NUM times and packs the buses.

## Test plan
- psc_tick=1, ch_pol=0, ch_in period 100 cycles, high 30 -> entries {100,30} each period. The first entry appears only after the second rising edge.
- ch_pol=1, same waveform -> entries {100,70}.
- flt_len=3, 2-cycle glitch on ch_in -> no edge, no entry. Then a 10-cycle pulse is accepted with latency +3.
- No pops, FIFO_DEPTH+2 periods -> cap_valid=1, FIFO holds the first 4 entries, cap_ovf=1. ovf_clr -> cap_ovf=0.
- CNT_W=8, ch_in stuck high after an active edge -> cnt_sat pulse after 255 ticks, no entry. The next period measures correctly.
- Assert apb_rst_n mid-LOW with 2 entries queued -> all outputs 0 immediately. After release, the first entry follows two fresh active edges.
